// File: rtl/bin2bcd7seg_disp.sv
// bin2bcd7seg_disp: takes a signed 8-bit add/subtract result, converts its magnitude
// to BCD with a shift-add-3 engine (8 clocks) and drives a multiplexed 4-digit
// active-low 7-segment display (sign, hundreds, tens, units).
module bin2bcd7seg_disp #(
   parameter int unsigned REFRESH_DIV = 50000,
   parameter bit          LZB         = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [7:0] din,
   input  logic       neg_in,
   output logic       busy,
   output logic       done,
   output logic [3:0] an,
   output logic [6:0] seg
);

   localparam logic IDLE = 1'b0;
   localparam logic CONV = 1'b1;

   localparam int unsigned     CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [CW-1:0]   TC = CW'(REFRESH_DIV - 1);
   localparam logic [6:0]      SEG_BLANK = 7'b1111111;
   localparam logic [6:0]      SEG_MINUS = 7'b1111110;

   logic        state;
   logic [7:0]  shift_reg;
   logic [11:0] bcd;
   logic [2:0]  step;
   logic        sign_cap;
   logic [3:0]  disp_h, disp_t, disp_u;
   logic        disp_neg;

   logic [7:0]  mag;
   logic [11:0] adj;
   logic [19:0] shifted;
   logic        commit;
   logic [3:0]  disp_h_n, disp_t_n, disp_u_n;
   logic        disp_neg_n;

   logic [CW-1:0] cnt;
   logic [1:0]    idx;
   logic [1:0]    idx_n;
   logic [6:0]    seg_n;

   function automatic logic [6:0] dec7(input logic [3:0] d);
      case (d)
         4'd0:    dec7 = 7'b0000001;
         4'd1:    dec7 = 7'b1001111;
         4'd2:    dec7 = 7'b0010010;
         4'd3:    dec7 = 7'b0000110;
         4'd4:    dec7 = 7'b1001100;
         4'd5:    dec7 = 7'b0100100;
         4'd6:    dec7 = 7'b0100000;
         4'd7:    dec7 = 7'b0001111;
         4'd8:    dec7 = 7'b0000000;
         4'd9:    dec7 = 7'b0000100;
         default: dec7 = SEG_BLANK;
      endcase
   endfunction

   // Magnitude, one add-3/shift step, and the display values as they will be after this edge
   always_comb begin
      mag = neg_in ? (~din + 8'd1) : din;
      for (int unsigned i = 0; i < 3; i++) begin
         adj[i*4 +: 4] = (bcd[i*4 +: 4] >= 4'd5) ? bcd[i*4 +: 4] + 4'd3 : bcd[i*4 +: 4];
      end
      shifted    = {adj, shift_reg} << 1;
      commit     = (state == CONV) && (step == 3'd7);
      disp_h_n   = commit ? shifted[19:16] : disp_h;
      disp_t_n   = commit ? shifted[15:12] : disp_t;
      disp_u_n   = commit ? shifted[11:8]  : disp_u;
      disp_neg_n = commit ? sign_cap       : disp_neg;
   end

   // Conversion FSM and committed display digits
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         busy      <= 1'b0;
         done      <= 1'b0;
         shift_reg <= '0;
         bcd       <= '0;
         step      <= '0;
         sign_cap  <= 1'b0;
         disp_h    <= '0;
         disp_t    <= '0;
         disp_u    <= '0;
         disp_neg  <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  shift_reg <= mag;
                  bcd       <= '0;
                  step      <= '0;
                  sign_cap  <= neg_in && (mag != 8'd0);
                  busy      <= 1'b1;
                  state     <= CONV;
               end
            end
            default: begin
               shift_reg <= shifted[7:0];
               bcd       <= shifted[19:8];
               step      <= step + 3'd1;
               if (commit) begin
                  disp_h   <= disp_h_n;
                  disp_t   <= disp_t_n;
                  disp_u   <= disp_u_n;
                  disp_neg <= disp_neg_n;
                  done     <= 1'b1;
                  busy     <= 1'b0;
                  state    <= IDLE;
               end
            end
         endcase
      end
   end

   // Next scan slot and its segment pattern; built from next-state values so an/seg
   // track the scan index and freshly committed digits without an extra cycle of lag
   always_comb begin
      idx_n = (cnt == TC) ? idx + 2'd1 : idx;
      case (idx_n)
         2'd0:    seg_n = dec7(disp_u_n);
         2'd1:    seg_n = (LZB && disp_h_n == 4'd0 && disp_t_n == 4'd0) ? SEG_BLANK : dec7(disp_t_n);
         2'd2:    seg_n = (LZB && disp_h_n == 4'd0) ? SEG_BLANK : dec7(disp_h_n);
         default: seg_n = disp_neg_n ? SEG_MINUS : SEG_BLANK;
      endcase
   end

   // Display scan: refresh counter, slot index and registered digit/segment drive
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
         idx <= '0;
         an  <= 4'b1110;
         seg <= 7'b0000001;
      end else begin
         cnt <= (cnt == TC) ? '0 : cnt + 1'b1;
         idx <= idx_n;
         an  <= ~(4'b0001 << idx_n);
         seg <= seg_n;
      end
   end

endmodule
